ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side engine for the 8x16 dual-port RAM, on the read-clock domain.
- Accepts a burst command (base address, length) and drives the RAM read port (re, rd_addr).
- Returns the read words as a valid/ready stream, using a 2-entry output buffer for backpressure.
- Counterpart to the write-side path that fills the RAM; it replaces hand-driven read tasks with a self-sequencing reader.

Parameters:
- RAM_WIDTH, 16, data word width
- RAM_DEPTH, 8, number of RAM words
- ADDR_SIZE, 3, RAM address width (log2 RAM_DEPTH)

Ports:
- clk  input  1  single clock (tied to the RAM rd_clk)
- clr_n  input  1  asynchronous active-low reset
- start  input  1  burst request, sampled on clk rising edge when idle
- base_addr  input  ADDR_SIZE  first RAM address of the burst
- len  input  ADDR_SIZE+1  word count; 0 = empty burst, values above RAM_DEPTH are clipped to RAM_DEPTH
- re  output  1  RAM read enable
- rd_addr  output  ADDR_SIZE  RAM read address
- ram_dout  input  RAM_WIDTH  RAM read data, valid in the cycle after re=1
- m_valid  output  1  stream data valid
- m_data  output  RAM_WIDTH  stream data
- m_last  output  1  marks the final beat of the burst
- m_ready  input  1  downstream accept
- busy  output  1  high from command acceptance until done
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (clr_n=0, asynchronous): re, rd_addr, m_valid, m_data, m_last, busy and done are all 0. Buffer is empty, in-flight counter is 0, state is IDLE.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - start=1 with effective len>0: latch base_addr and effective len, go to ISSUE, busy=1 next cycle.
  - start=1 with len=0: go to FINISH with no re.
- ISSUE:
  - re=1 when credit exists: occupancy + inflight - pop < 2, where pop = m_valid & m_ready this cycle.
  - Each issue drives rd_addr = current address. Address increments modulo RAM_DEPTH (7 wraps to 0). Remaining count decrements.
  - After the last issue, go to DRAIN.
- Read latency: ram_dout is written into the buffer on the edge following the re cycle. The inflight counter (0..2) tracks outstanding reads.
- Start to first beat: command edge E0; re in cycle E0..E1; data captured at E2; m_valid=1 after E2.
- Throughput: with m_ready held at 1, one beat per cycle with no gaps.
- Buffer: 2-entry FIFO; m_data/m_valid come from the head.
  - Simultaneous push and pop is allowed at any occupancy.
  - The buffer never overflows, by construction of the credit rule.
- Stream handshake: a beat is transferred when m_valid & m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- m_last=1 only on the beat whose index equals effective len-1. A per-entry last flag is stored in the buffer.
- DRAIN: wait until inflight=0 and buffer empty, then go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 from that cycle, return to IDLE. For len=0, done is asserted in the cycle after start.
- start while busy is ignored. No queuing, no error flag.
- re is never asserted outside ISSUE. rd_addr holds its last value when re=0.
- Reset mid-burst: immediate return to the reset values. Outstanding RAM data arriving afterwards is discarded.

Decomposition:
- Shared package (ram_pkg): RAM_WIDTH, RAM_DEPTH and ADDR_SIZE constants shared with the RAM and write-side blocks, plus the state encoding enum for this FSM.
- One sub-module: ram_skid_fifo2, a 2-entry RAM_WIDTH+1 wide FIFO carrying data and the last flag, with push, pop, count, head outputs and the same clk/clr_n.
- FSM, address/count logic and the credit counter stay in the top module.

Test Plan:
- Setup: the RAM model is preloaded with mem[i]=16'h00A0+i.
- Reset: assert clr_n=0 mid-simulation -> all outputs 0 immediately. Release, then start base=0 len=8 with m_ready=1 -> m_data A0..A7 on 8 consecutive cycles, m_last only on A7, first m_valid 2 cycles after start, done pulse once, busy low after.
- Wrap: base=6 len=4 -> rd_addr sequence 6,7,0,1; data A6,A7,A0,A1; m_last on A1.
- Backpressure: base=2 len=5 with m_ready pattern 1,0,0,1,0,1,1,1,... -> stream exactly A2..A6 with no loss or duplicate. Data stable while stalled. The checker asserts occupancy+inflight≤2 every cycle.
- Edge lengths:
  - len=0 -> done next cycle, re never asserted, no m_valid.
  - len=12 -> clipped to 8 beats.
- Busy start and reset mid-burst:
  - start pulsed during an active burst -> ignored; only the original burst completes.
  - clr_n=0 after 3 beats of a len=8 burst -> m_valid/busy/re drop to 0 at once, no done.
  - A new burst after reset works normally.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the 8x16 dual-port RAM and its read/write engines,
// plus the state encoding of the burst reader FSM.
package ram_pkg;

  localparam int unsigned RAM_WIDTH = 16;
  localparam int unsigned RAM_DEPTH = 8;
  localparam int unsigned ADDR_SIZE = 3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFinish
  } rd_state_e;

endpackage

// File: rtl/ram_skid_fifo2.sv
// Two-entry FIFO that absorbs read data while the stream consumer stalls.
// Ports:
//   clk, clr_n - clock and asynchronous active-low reset
//   i_push     - write i_data into the tail
//   i_data     - entry to store
//   i_pop      - remove the head entry
//   o_count    - current occupancy (0..2)
//   o_head     - head entry, meaningful only while o_count != 0
module ram_skid_fifo2 #(
  parameter int unsigned Width = 17
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic [Width-1:0] o_head
);

  logic [Width-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_burst_reader.sv
// Self-sequencing burst reader for the 8x16 RAM read port. A command
// (base_addr, len) issues up to RAM_DEPTH reads with wrapping addresses and
// returns the words as a valid/ready stream through a two-entry buffer.
// Ports:
//   clk, clr_n          - read clock and asynchronous active-low reset
//   start, base_addr    - burst request and first address (sampled when idle)
//   len                 - word count, 0 = empty burst, clipped to RAM_DEPTH
//   re, rd_addr         - RAM read port
//   ram_dout            - RAM read data, valid the cycle after re
//   m_valid, m_data,
//   m_last, m_ready     - output stream
//   busy, done          - burst in progress / one-cycle completion pulse
module ram_burst_reader
  import ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE:0]   len,
  output logic                 re,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic                 m_valid,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_SIZE:0] MaxLen = (ADDR_SIZE + 1)'(RAM_DEPTH);
  localparam logic [ADDR_SIZE:0] OneLen = (ADDR_SIZE + 1)'(1);

  rd_state_e            r_state;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [ADDR_SIZE:0]   r_remain;
  logic [1:0]           r_inflight;
  logic                 r_re_q;
  logic                 r_re_last_q;
  logic                 r_busy;
  logic                 r_done;

  logic [1:0]           w_count;
  logic [RAM_WIDTH:0]   w_head;
  logic                 w_pop;
  logic [2:0]           w_occ_sum;
  logic                 w_credit;
  logic                 w_re;
  logic                 w_issue_last;
  logic [ADDR_SIZE:0]   w_eff_len;

  assign w_eff_len = (len > MaxLen) ? MaxLen : len;

  assign m_valid = (w_count != 2'd0);
  assign m_data  = w_head[RAM_WIDTH-1:0];
  // Gate with valid so a stale flag in the idle slot never shows.
  assign m_last  = w_head[RAM_WIDTH] & m_valid;
  assign w_pop   = m_valid & m_ready;

  // Buffered plus outstanding words may never exceed the two buffer slots;
  // a pop this cycle frees a slot for a read issued in the same cycle.
  assign w_occ_sum    = {1'b0, w_count} + {1'b0, r_inflight} - {2'b00, w_pop};
  assign w_credit     = (w_occ_sum < 3'd2);
  assign w_re         = (r_state == StIssue) & w_credit;
  assign w_issue_last = w_re & (r_remain == OneLen);

  assign re      = w_re;
  assign rd_addr = w_re ? r_addr : r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_remain    <= '0;
      r_inflight  <= 2'd0;
      r_re_q      <= 1'b0;
      r_re_last_q <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Read data lands one cycle after re; r_re_q marks it for the buffer.
      r_re_q      <= w_re;
      r_re_last_q <= w_issue_last;
      r_inflight  <= r_inflight + {1'b0, w_re} - {1'b0, r_re_q};
      if (w_re) begin
        r_rd_addr <= r_addr;
      end
      r_done <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (w_eff_len != '0) begin
              r_addr   <= base_addr;
              r_remain <= w_eff_len;
              r_busy   <= 1'b1;
              r_state  <= StIssue;
            end else begin
              r_done  <= 1'b1;
              r_state <= StFinish;
            end
          end
        end
        StIssue: begin
          if (w_re) begin
            r_addr   <= r_addr + ADDR_SIZE'(1);
            r_remain <= r_remain - OneLen;
            if (r_remain == OneLen) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (r_inflight == 2'd0 && w_count == 2'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StFinish;
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  ram_skid_fifo2 #(
    .Width(RAM_WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_push (r_re_q),
    .i_data ({r_re_last_q, ram_dout}),
    .i_pop  (w_pop),
    .o_count(w_count),
    .o_head (w_head)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a synchronous-read RAM model
// preloaded with mem[i] = 16'h00A0 + i.
module tb_ram_burst_reader;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [2:0]  base_addr;
  logic [3:0]  len;
  logic        re;
  logic [2:0]  rd_addr;
  logic [15:0] ram_dout;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;

  ram_burst_reader dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .re       (re),
    .rd_addr  (rd_addr),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h00A0 + 16'(i);
    ram_dout = '0;
  end
  always @(posedge clk) if (re) ram_dout <= mem[rd_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [15:0] q_data [$];
  logic        q_last [$];
  int          q_cyc  [$];
  logic [2:0]  q_addr [$];
  int          cyc = 0;
  int          n_done = 0;
  int          n_unstable = 0;
  int          n_credit_viol = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  logic        stall_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_cyc.push_back(cyc);
    end
    if (re) q_addr.push_back(rd_addr);
    if (done) n_done++;
    if (stall_prev && (!m_valid || m_data !== stall_data || m_last !== stall_last))
      n_unstable++;
    stall_prev = m_valid && !m_ready;
    stall_data = m_data;
    stall_last = m_last;
    if (int'(dut.w_count) + int'(dut.r_inflight) > 2) n_credit_viol++;
  end

  function automatic logic [15:0] exp_word(input int a);
    return 16'h00A0 + 16'(a % 8);
  endfunction

  task automatic clear_log();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    q_addr.delete();
    n_done = 0;
    n_unstable = 0;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic start_burst(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 3'(b);
    len = 4'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // pat bit k is m_ready for the k-th cycle after command acceptance.
  task automatic run_until_done(input int max_cyc, input logic [15:0] pat, input int plen,
                                output logic seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      m_ready = (k < plen) ? pat[k] : 1'b1;
      if (n_done > 0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
  endtask

  task automatic check_burst(input string tag, input int b, input int n);
    check_eq({tag, "_beats"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), q_data[i], exp_word(b + i));
      check_eq($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1));
    end
  endtask

  task automatic check_addrs(input string tag, input int b, input int n);
    check_eq({tag, "_reads"}, q_addr.size(), n);
    for (int i = 0; i < n && i < q_addr.size(); i++)
      check_eq($sformatf("%s_addr%0d", tag, i), q_addr[i], (b + i) % 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_re"}, re, 0);
    check_eq({tag, "_rd_addr"}, rd_addr, 0);
    check_eq({tag, "_m_valid"}, m_valid, 0);
    check_eq({tag, "_m_data"}, m_data, 0);
    check_eq({tag, "_m_last"}, m_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  logic seen;

  initial begin
    clr_n = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    m_ready = 1'b1;
    #1 clr_n = 1'b0;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;

    // Full burst, latency and back-to-back throughput.
    clear_log();
    start_burst(0, 8);
    check_eq("lat_busy", busy, 1);
    check_eq("lat_re", re, 1);
    check_eq("lat_addr0", rd_addr, 0);
    check_eq("lat_valid_e0", m_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_valid_e1", m_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_valid_e2", m_valid, 1);
    check_eq("lat_data_e2", m_data, 16'h00A0);
    run_until_done(40, 16'hFFFF, 0, seen);
    check_eq("full_done_seen", seen, 1);
    check_burst("full", 0, 8);
    check_addrs("full", 0, 8);
    if (q_cyc.size() == 8) check_eq("full_gapless", q_cyc[7] - q_cyc[0], 7);
    check_eq("full_busy_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("full_done_once", n_done, 1);

    // Address wrap.
    clear_log();
    start_burst(6, 4);
    run_until_done(40, 16'hFFFF, 0, seen);
    check_eq("wrap_done_seen", seen, 1);
    check_burst("wrap", 6, 4);
    check_addrs("wrap", 6, 4);

    // Backpressure: ready pattern 1,0,0,1,0,1,1,1 then held high.
    clear_log();
    start_burst(2, 5);
    run_until_done(60, 16'b1110_1001, 8, seen);
    check_eq("bp_done_seen", seen, 1);
    check_burst("bp", 2, 5);
    check_eq("bp_stable", n_unstable, 0);

    // Empty burst.
    clear_log();
    start_burst(0, 0);
    check_eq("len0_done", done, 1);
    check_eq("len0_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("len0_done_once", n_done, 1);
    check_eq("len0_no_re", q_addr.size(), 0);
    check_eq("len0_no_beat", q_data.size(), 0);

    // Length clipped to the RAM depth.
    clear_log();
    start_burst(3, 12);
    run_until_done(60, 16'hFFFF, 0, seen);
    check_eq("clip_done_seen", seen, 1);
    check_burst("clip", 3, 8);
    check_addrs("clip", 3, 8);

    // start while busy is ignored.
    clear_log();
    start_burst(0, 4);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 3'd5;
    len = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(40, 16'hFFFF, 0, seen);
    check_eq("ign_done_seen", seen, 1);
    repeat (6) @(posedge clk);
    #1;
    check_burst("ign", 0, 4);
    check_eq("ign_done_once", n_done, 1);
    check_eq("ign_reads", q_addr.size(), 4);

    // Reset after three beats of a full burst.
    clear_log();
    start_burst(0, 8);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (q_data.size() >= 3) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("mid_three_beats", seen, 1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    clr_n = 1'b1;
    check_eq("mid_no_done", n_done, 0);
    check_eq("mid_beats_kept", q_data.size(), 3);

    // Normal burst after reset.
    clear_log();
    start_burst(4, 3);
    run_until_done(40, 16'hFFFF, 0, seen);
    check_eq("post_done_seen", seen, 1);
    check_burst("post", 4, 3);
    check_addrs("post", 4, 3);

    check_eq("credit_bound", n_credit_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
